// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and byte-lane helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_X = 2'b11} size_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_WAIT = 2'b01, ST_ACK = 2'b10} state_e;
  localparam logic [3:0] OFF_MTIME_LO    = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI    = 4'h4;
  localparam logic [3:0] OFF_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP_HI = 4'hC;
  // Byte enables of the lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr);
    lane_be = size == SIZE_B ? 4'b0001 << addr :
              size == SIZE_H ? (addr[1] ? 4'b1100 : 4'b0011) :
              size == SIZE_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core load/store port bundle between requester (master) and responder (slave)
interface dmem_responder_if;
  logic        req;
  logic [31:0] address;
  logic [1:0]  size;
  logic        write_data_sig;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        wait_sig;
  logic        err;
  modport master (output req, address, size, write_data_sig, write_data,
                  input  read_data, wait_sig, err);
  modport slave  (input  req, address, size, write_data_sig, write_data,
                  output read_data, wait_sig, err);
endinterface

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: single-port synchronous RAM with byte enables; a read during a write returns old data
module dmem_ram_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  // Byte-masked write and registered read of the addressed word on one enable.
  always_ff @(posedge clk)
    if (en_i) begin
      for (int i = 0; i < 4; i++)
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated RAM responder with fault detection; DMEM_TIMER_EN adds an mtime/mtimecmp timer
module dmem_responder import dmem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0200_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_responder_if.slave    bus,
  output logic               timer_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
`ifdef DMEM_TIMER_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic          flt_q;
  logic          tmr_q;
  logic          in_ram;
  logic          in_tmr;
  logic          fault;
  logic          commit;
  logic [31:0]   ram_rd;
  logic [31:0]   rd_mask;
  logic [31:0]   rd_lane;
  logic [31:0]   tmr_rd;
  // RAM window is aligned to its size, so the upper address bits alone decide membership and
  // BASE_ADDR+4*DEPTH_WORDS can never alias word 0.
  assign in_ram = bus.address[31:AW+2] == BASE_ADDR[31:AW+2];
  assign in_tmr = TMR_EN && bus.address[31:4] == MMIO_BASE[31:4];
  assign fault  = bus.size == SIZE_X ||
                  (bus.size == SIZE_H && bus.address[0]) ||
                  (bus.size == SIZE_W && |bus.address[1:0]) ||
                  !(in_ram || in_tmr) ||
                  (in_tmr && bus.size != SIZE_W);
  assign commit = state_q == ST_WAIT && cnt_q == 4'd0;
  // Request latch, wait-state countdown and ACK sequencing.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      flt_q   <= 1'b0;
      tmr_q   <= 1'b0;
    end else
      case (state_q)
        ST_IDLE:
          if (bus.req) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_INIT;
            addr_q  <= bus.address[AW+1:0];
            size_q  <= bus.size;
            we_q    <= bus.write_data_sig;
            wdata_q <= bus.write_data;
            flt_q   <= fault;
            tmr_q   <= in_tmr;
          end
        ST_WAIT:
          if (cnt_q == 4'd0) state_q <= ST_ACK;
          else cnt_q <= cnt_q - 4'd1;
        default: state_q <= ST_IDLE;
      endcase
  // The RAM is touched only at the WAIT->ACK edge, and never for faulted or timer accesses.
  dmem_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .en_i    (commit && !flt_q && !tmr_q),
    .we_i    (we_q ? lane_be(size_q, addr_q[1:0]) : 4'b0000),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q << {addr_q[1:0], 3'b000}),
    .rdata_o (ram_rd)
  );
  assign rd_mask = size_q == SIZE_B ? 32'h0000_00FF : size_q == SIZE_H ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign rd_lane = (ram_rd >> {addr_q[1:0], 3'b000}) & rd_mask;
  assign bus.wait_sig  = state_q == ST_WAIT || (state_q == ST_IDLE && bus.req);
  assign bus.err       = state_q == ST_ACK && flt_q;
  assign bus.read_data = (state_q == ST_ACK && !we_q && !flt_q) ? (tmr_q ? tmr_rd : rd_lane) : '0;
`ifdef DMEM_TIMER_EN
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        irq_q;
  logic [31:0] tmr_rd_q;
  logic        tmr_wr;
  assign tmr_wr = commit && tmr_q && !flt_q && we_q;
  // Free-running mtime (a store overrides that cycle's increment), mtimecmp, registered compare and read port.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
      tmr_rd_q   <= '0;
    end else begin
      mtime_q <= (tmr_wr && addr_q[3:0] == OFF_MTIME_LO) ? {mtime_q[63:32], wdata_q} :
                 (tmr_wr && addr_q[3:0] == OFF_MTIME_HI) ? {wdata_q, mtime_q[31:0]} :
                 mtime_q + 64'd1;
      if (tmr_wr && addr_q[3:0] == OFF_MTIMECMP_LO) mtimecmp_q[31:0]  <= wdata_q;
      if (tmr_wr && addr_q[3:0] == OFF_MTIMECMP_HI) mtimecmp_q[63:32] <= wdata_q;
      irq_q <= mtime_q >= mtimecmp_q;
      if (commit) tmr_rd_q <= addr_q[3:0] == OFF_MTIME_LO    ? mtime_q[31:0] :
                              addr_q[3:0] == OFF_MTIME_HI    ? mtime_q[63:32] :
                              addr_q[3:0] == OFF_MTIMECMP_LO ? mtimecmp_q[31:0] : mtimecmp_q[63:32];
    end
  assign tmr_rd    = tmr_rd_q;
  assign timer_irq = irq_q;
`else
  assign tmr_rd    = '0;
  assign timer_irq = 1'b0;
`endif
endmodule
